// File: rtl/bloco_ula_mc_pkg.sv
// bloco_pkg: shared types for the bloco_ula_mc datapath.
//   op_t       - 5-bit opcode driven by the control unit
//   FLAG_*     - bit positions inside the 4-bit Flags bus {N,Z,C,V}
//   est_mul_t  - states of the multi-cycle multiply sequencer
package bloco_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_NOT  = 5'b00101,
    OP_SHL  = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_ASR  = 5'b01000,
    OP_PASS = 5'b01001,
    OP_INC  = 5'b01010,
    OP_DEC  = 5'b01011,
    OP_MUL  = 5'b01100,
    OP_LOAD = 5'b01101
  } op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    OCIOSO = 1'b0,
    MULT   = 1'b1
  } est_mul_t;

endpackage

// File: rtl/bloco_ula_mc_if.sv
// bloco_ula_mc_if: bus between the control unit (master) and the datapath (slave).
//   master drives: Hab_Escrita, Sel_SA/SB/SC, controleOperacao, Entrada_Dados, limpa_Flags
//   slave  drives: Saida_A, Saida_B, Flags {N,Z,C,V}, ocupado, pronto
interface bloco_ula_mc_if #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2
);
  logic                     Hab_Escrita;
  logic [end_registros-1:0] Sel_SA;
  logic [end_registros-1:0] Sel_SB;
  logic [end_registros-1:0] Sel_SC;
  logic [4:0]               controleOperacao;
  logic [bits_palavra-1:0]  Entrada_Dados;
  logic                     limpa_Flags;
  logic [bits_palavra-1:0]  Saida_A;
  logic [bits_palavra-1:0]  Saida_B;
  logic [3:0]               Flags;
  logic                     ocupado;
  logic                     pronto;

  modport master (
    output Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao, Entrada_Dados, limpa_Flags,
    input  Saida_A, Saida_B, Flags, ocupado, pronto
  );

  modport slave (
    input  Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao, Entrada_Dados, limpa_Flags,
    output Saida_A, Saida_B, Flags, ocupado, pronto
  );
endinterface

// File: rtl/bloco_ula_mc_mult_seq.sv
// mult_seq: sequential shift-add multiplier, one partial product per clock.
//   clk, reset  - clock, synchronous active-high reset (aborts a running product)
//   inicia      - latch a/b and start; ignored while a product is running
//   a, b        - operands (unsigned)
//   fim         - high during the cycle whose rising edge completes the product
//   produto     - accumulator including the current iteration; valid when fim=1
// produto is combinational so the owner can write it at the very edge that
// finishes the last iteration, without an extra cycle.
module mult_seq #(
  parameter int bits_palavra = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inicia,
  input  logic [bits_palavra-1:0]   a,
  input  logic [bits_palavra-1:0]   b,
  output logic                      fim,
  output logic [2*bits_palavra-1:0] produto
);
  localparam int W  = bits_palavra;
  localparam int CW = $clog2(W);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           ativo;

  assign produto = acc + (mplier[0] ? mcand : '0);
  assign fim     = ativo && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      ativo  <= 1'b0;
    end else if (inicia && !ativo) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      ativo  <= 1'b1;
    end else if (ativo) begin
      acc    <= produto;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (fim) ativo <= 1'b0;
    end
  end
endmodule

// File: rtl/bloco_ula_mc.sv
// bloco_ula_mc: register bank + ALU with registered flags, immediate load and
// an optional multi-cycle multiplier.
//   clk, reset - clock, synchronous active-high reset
//   bus (slave modport of bloco_ula_mc_if):
//     Hab_Escrita      operation request, accepted when ocupado is low
//     Sel_SA/SB/SC     operand A / operand B / destination register addresses
//     controleOperacao opcode (op_t)
//     Entrada_Dados    immediate for LOAD
//     limpa_Flags      synchronous flag clear (beats any flag update)
//     Saida_A/B        combinational register reads (old value until the edge)
//     Flags            {N,Z,C,V}, registered
//     ocupado, pronto  multiplier busy level / one-cycle completion pulse
// Build option: define MUL_EN to include the multiplier (OP_MUL, FSM, mult_seq).
// Without it OP_MUL is a NOP and ocupado/pronto are constant 0.
module bloco_ula_mc
  import bloco_pkg::*;
#(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2
) (
  input  logic          clk,
  input  logic          reset,
  bloco_ula_mc_if.slave bus
);
  localparam int W    = bits_palavra;
  localparam int NREG = 2 ** end_registros;

  logic [W-1:0] regs [NREG];
  logic [3:0]   flags_r;

  op_t          op;
  logic [W-1:0] a, b, res;
  logic [W:0]   soma;
  logic         c_alu, v_alu, escreve, aceita;

  assign bus.Saida_A = regs[bus.Sel_SA];
  assign bus.Saida_B = regs[bus.Sel_SB];
  assign bus.Flags   = flags_r;
  assign op          = op_t'(bus.controleOperacao);
  assign a           = bus.Saida_A;
  assign b           = bus.Saida_B;

  // ---------------- ALU (single-cycle ops) ----------------
  always_comb begin
    res     = '0;
    soma    = '0;
    c_alu   = 1'b0;
    v_alu   = 1'b0;
    escreve = 1'b1;
    case (op)
      OP_ADD: begin
        soma  = {1'b0, a} + {1'b0, b};
        res   = soma[W-1:0];
        c_alu = soma[W];
        v_alu = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        // top bit of the W+1 bit difference is the unsigned borrow
        soma  = {1'b0, a} - {1'b0, b};
        res   = soma[W-1:0];
        c_alu = soma[W];
        v_alu = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      OP_INC: begin
        soma  = {1'b0, a} + {{W{1'b0}}, 1'b1};
        res   = soma[W-1:0];
        c_alu = soma[W];
        v_alu = !a[W-1] && res[W-1];
      end
      OP_DEC: begin
        soma  = {1'b0, a} - {{W{1'b0}}, 1'b1};
        res   = soma[W-1:0];
        c_alu = soma[W];
        v_alu = a[W-1] && !res[W-1];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL: begin
        res   = {a[W-2:0], 1'b0};
        c_alu = a[W-1];
      end
      OP_SHR: begin
        res   = {1'b0, a[W-1:1]};
        c_alu = a[0];
      end
      OP_ASR: begin
        res   = {a[W-1], a[W-1:1]};
        c_alu = a[0];
      end
      OP_PASS: res = a;
      OP_LOAD: res = bus.Entrada_Dados;
      default: escreve = 1'b0;   // NOP; OP_MUL is handled by the sequencer
    endcase
  end

`ifdef MUL_EN
  // ---------------- multiply sequencer ----------------
  est_mul_t                 est, prox_est;
  logic                     ocupado_i, pronto_r, inicia, fim;
  logic [2*W-1:0]           produto;
  logic [end_registros-1:0] rc_mul;

  assign aceita = bus.Hab_Escrita && !ocupado_i;
  assign inicia = aceita && (op == OP_MUL);

  always_ff @(posedge clk) begin
    if (reset) est <= OCIOSO;
    else       est <= prox_est;
  end

  always_comb begin
    prox_est = est;
    case (est)
      OCIOSO:  if (inicia) prox_est = MULT;
      MULT:    if (fim)    prox_est = OCIOSO;
      default: prox_est = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado_i = (est == MULT);
  end

  // pronto follows the completing edge by exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pronto_r <= 1'b0;
      rc_mul   <= '0;
    end else begin
      pronto_r <= fim;
      if (inicia) rc_mul <= bus.Sel_SC;
    end
  end

  mult_seq #(.bits_palavra(W)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .inicia  (inicia),
    .a       (a),
    .b       (b),
    .fim     (fim),
    .produto (produto)
  );

  assign bus.ocupado = ocupado_i;
  assign bus.pronto  = pronto_r;
`else
  assign aceita      = bus.Hab_Escrita;
  assign bus.ocupado = 1'b0;
  assign bus.pronto  = 1'b0;
`endif

  // ---------------- register bank ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (aceita && escreve) regs[bus.Sel_SC] <= res;
`ifdef MUL_EN
      // no accept can coincide with fim: ocupado is still high that cycle
      if (fim) regs[rc_mul] <= produto[W-1:0];
`endif
    end
  end

  // ---------------- flags ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= '0;
    end else if (bus.limpa_Flags) begin
      flags_r <= '0;
    end else if (aceita && escreve) begin
      flags_r[FLAG_N] <= res[W-1];
      flags_r[FLAG_Z] <= (res == '0);
      flags_r[FLAG_C] <= c_alu;
      flags_r[FLAG_V] <= v_alu;
    end
`ifdef MUL_EN
    else if (fim) begin
      flags_r[FLAG_N] <= produto[W-1];
      flags_r[FLAG_Z] <= (produto[W-1:0] == '0);
      flags_r[FLAG_C] <= (produto[2*W-1:W] != '0);
      flags_r[FLAG_V] <= 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_bloco_ula_mc.sv
module tb_bloco_ula_mc;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bloco_ula_mc_if #(.bits_palavra(16), .end_registros(2)) bus ();

  bloco_ula_mc #(.bits_palavra(16), .end_registros(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  rc;
    logic [15:0] v;
    logic [3:0]  f;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one request across the next rising edge.
  task automatic issue(input logic [4:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] sc, input logic [15:0] d, input logic lf,
                       input logic push, input logic [15:0] ev, input logic [3:0] ef);
    exp_t e;
    bus.controleOperacao = op;
    bus.Sel_SA = sa;
    bus.Sel_SB = sb;
    bus.Sel_SC = sc;
    bus.Entrada_Dados = d;
    bus.limpa_Flags = lf;
    bus.Hab_Escrita = 1'b1;
    if (push) begin
      e.rc = sc; e.v = ev; e.f = ef;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    bus.Hab_Escrita = 1'b0;
    bus.limpa_Flags = 1'b0;
  endtask

  task automatic retire(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      bus.Sel_SA = e.rc;
      #1;
      chk({tag, "_val"}, 32'(bus.Saida_A), 32'(e.v));
      chk({tag, "_flags"}, 32'(bus.Flags), 32'(e.f));
    end
  endtask

  // Single-cycle op: result is visible right after the accepting edge.
  task automatic op1(input string tag, input logic [4:0] op, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] sc, input logic [15:0] d,
                     input logic lf, input logic [15:0] ev, input logic [3:0] ef);
    issue(op, sa, sb, sc, d, lf, 1'b1, ev, ef);
    retire(tag);
  endtask

`ifdef MUL_EN
  // Entered at the negedge after the MUL accept; optionally fires a LOAD R0 mid-run.
  task automatic mul_wait(input string tag, input logic inject);
    int cnt = 0;
    while (bus.ocupado && cnt < 40) begin
      cnt++;
      if (inject && cnt == 5) begin
        bus.controleOperacao = 5'b01101;
        bus.Sel_SC = 2'd0;
        bus.Entrada_Dados = 16'hABCD;
        bus.Hab_Escrita = 1'b1;
      end else begin
        bus.Hab_Escrita = 1'b0;
      end
      @(negedge clk);
    end
    bus.Hab_Escrita = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd16);
    chk({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
    retire(tag);
    @(negedge clk);
    chk({tag, "_pronto_drop"}, 32'(bus.pronto), 32'd0);
  endtask
`endif

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.Sel_SA = 2'(i);
      bus.Sel_SB = 2'(3 - i);
      #1;
      chk({tag, "_ra"}, 32'(bus.Saida_A), 32'd0);
      chk({tag, "_rb"}, 32'(bus.Saida_B), 32'd0);
    end
    chk({tag, "_flags"}, 32'(bus.Flags), 32'd0);
    chk({tag, "_ocupado"}, 32'(bus.ocupado), 32'd0);
    chk({tag, "_pronto"}, 32'(bus.pronto), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int np;
    reset = 1'b1;
    bus.Hab_Escrita = 1'b0;
    bus.Sel_SA = '0;
    bus.Sel_SB = '0;
    bus.Sel_SC = '0;
    bus.controleOperacao = '0;
    bus.Entrada_Dados = '0;
    bus.limpa_Flags = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    // Flags are {N,Z,C,V}
    op1("load_r1",   5'b01101, 0, 0, 1, 16'h7FFF, 0, 16'h7FFF, 4'b0000);
    op1("load_r2",   5'b01101, 0, 0, 2, 16'h0001, 0, 16'h0001, 4'b0000);
    op1("add_ovf",   5'b00000, 1, 2, 3, 16'h0000, 0, 16'h8000, 4'b1001);
    op1("sub_zero",  5'b00001, 2, 2, 0, 16'h0000, 0, 16'h0000, 4'b0100);
    op1("dec_wrap",  5'b01011, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 4'b1010);
    op1("inc_wrap",  5'b01010, 0, 0, 0, 16'h0000, 0, 16'h0000, 4'b0110);
    op1("shl_out",   5'b00110, 3, 0, 3, 16'h0000, 0, 16'h0000, 4'b0110);
    op1("load_r3",   5'b01101, 0, 0, 3, 16'h8001, 0, 16'h8001, 4'b1000);
    op1("asr",       5'b01000, 3, 0, 3, 16'h0000, 0, 16'hC000, 4'b1010);
    op1("shr",       5'b00111, 3, 0, 3, 16'h0000, 0, 16'h6000, 4'b0000);
    op1("xor_self",  5'b00100, 3, 3, 3, 16'h0000, 0, 16'h0000, 4'b0100);
    op1("load_neg",  5'b01101, 0, 0, 1, 16'h8000, 0, 16'h8000, 4'b1000);
    op1("sub_ovf",   5'b00001, 1, 2, 3, 16'h0000, 0, 16'h7FFF, 4'b0001);
    op1("nop",       5'b11111, 1, 2, 3, 16'h1234, 0, 16'h7FFF, 4'b0001);

`ifdef MUL_EN
    op1("load_m1",   5'b01101, 0, 0, 1, 16'h0003, 0, 16'h0003, 4'b0000);
    op1("load_m2",   5'b01101, 0, 0, 2, 16'h0005, 0, 16'h0005, 4'b0000);
    issue(5'b01100, 1, 2, 3, 16'h0000, 0, 1'b1, 16'h000F, 4'b0000);
    mul_wait("mul_3x5", 1'b1);
    bus.Sel_SB = 2'd0;
    #1;
    chk("load_ignored_r0", 32'(bus.Saida_B), 32'h0000);
    op1("load_m3",   5'b01101, 0, 0, 1, 16'h0100, 0, 16'h0100, 4'b0000);
    issue(5'b01100, 1, 1, 2, 16'h0000, 0, 1'b1, 16'h0000, 4'b0110);
    mul_wait("mul_hi", 1'b0);
`else
    op1("mul_nop",   5'b01100, 1, 2, 3, 16'h0000, 0, 16'h7FFF, 4'b0001);
    chk("mul_nop_ocupado", 32'(bus.ocupado), 32'd0);
`endif

    op1("load_r1b",  5'b01101, 0, 0, 1, 16'h0100, 0, 16'h0100, 4'b0000);
    op1("add_limpa", 5'b00000, 1, 1, 3, 16'h0000, 1, 16'h0200, 4'b0000);

    // Reset in the middle of a multiply: nothing may complete afterwards.
`ifdef MUL_EN
    issue(5'b01100, 1, 1, 0, 16'h0000, 0, 1'b0, 16'h0000, 4'b0000);
    repeat (7) @(negedge clk);
    chk("mid_mul_busy", 32'(bus.ocupado), 32'd1);
`endif
    reset = 1'b1;
    @(negedge clk);
    check_cleared("mid_reset");
    reset = 1'b0;
    np = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.pronto) np++;
    end
    chk("no_pronto_after_reset", 32'(np), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
